// File: rtl/block_xfer_pkg.sv
// Shared types, constants and helpers for the LDM/STM block-transfer sequencer.
package block_xfer_pkg;

    localparam int WORD_BYTES = 4;
    localparam int NREGS      = 16;

    typedef enum logic [1:0] {
        MODE_IA = 2'd0,
        MODE_IB = 2'd1,
        MODE_DA = 2'd2,
        MODE_DB = 2'd3
    } xfer_mode_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        XFER = 3'd1,
        LAST = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } xfer_state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/reg_list_scan.sv
// Combinational scan of the remaining register list: lowest set index and any-set flag.
module reg_list_scan
    import block_xfer_pkg::*;
#(
    parameter int  LIST_W = NREGS,
    localparam int IW     = $clog2(LIST_W)
) (
    input  logic [LIST_W-1:0] list,
    output logic [IW-1:0]     idx,
    output logic              any
);

    // Walking downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (list[i]) idx = IW'(i);
        end
    end

    assign any = |list;

endmodule

// File: rtl/block_xfer_seq.sv
// LDM/STM block-transfer sequencer: walks the register list, issues one memory beat
// per register, writes loaded data back to the register file and optionally updates Rn.
module block_xfer_seq #(
    parameter int  WORD_BYTES = block_xfer_pkg::WORD_BYTES,
    parameter int  NREGS      = block_xfer_pkg::NREGS,
    localparam int IW         = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NREGS-1:0] reg_list,
    input  logic [IW-1:0]    rn,
    input  logic [31:0]      base_val,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic             wback,
    output logic             busy,
    output logic             done,
    output logic             pc_loaded,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic [IW-1:0]    rf_rd_addr,
    input  logic [31:0]      rf_rd_data,
    output logic             rf_w_en,
    output logic [IW-1:0]    rf_w_addr,
    output logic [31:0]      rf_w_data
);

    import block_xfer_pkg::*;

    xfer_state_e      state_q, state_d;
    logic [NREGS-1:0] list_q, list_next;
    logic [31:0]      addr_q, wb_val_q;
    logic [IW-1:0]    rn_q;
    logic             load_q, wback_q, pc_bit_q, rn_hit_q;

    logic             pend_q;
    logic [IW-1:0]    pend_addr_q;
    logic [31:0]      pend_data_q;

    logic [IW-1:0]    cur_idx;
    logic             any_left;
    logic             accept, last_beat;

    logic [4:0]       n_regs;
    logic [31:0]      span, start_addr, wb_val;

    reg_list_scan #(.LIST_W(NREGS)) u_scan (
        .list (list_q),
        .idx  (cur_idx),
        .any  (any_left)
    );

    assign accept    = (state_q == XFER) && any_left && mem_ready;
    assign list_next = list_q & ~(NREGS'(1) << cur_idx);
    assign last_beat = accept && (list_next == '0);

    // The block occupies [lowest, lowest+span) and is always walked upwards.
    always_comb begin
        n_regs     = popcount16(reg_list);
        span       = 32'(WORD_BYTES) * 32'(n_regs);
        start_addr = base_val;
        wb_val     = base_val + span;
        case (xfer_mode_e'(mode))
            MODE_IA: start_addr = base_val;
            MODE_IB: start_addr = base_val + 32'(WORD_BYTES);
            MODE_DA: start_addr = base_val - span + 32'(WORD_BYTES);
            MODE_DB: start_addr = base_val - span;
            default: start_addr = base_val;
        endcase
        if (mode[1]) wb_val = base_val - span;
    end

    // NOTE: only control state (FSM, pending-write flag) is reset; datapath
    // registers are always qualified by it, so their reset values never reach a port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            state_q <= state_d;
            pend_q  <= accept && load_q;
            if (state_q == IDLE && start) begin
                list_q   <= reg_list;
                addr_q   <= start_addr;
                wb_val_q <= wb_val;
                rn_q     <= rn;
                load_q   <= load;
                wback_q  <= wback;
                pc_bit_q <= reg_list[NREGS-1];
                rn_hit_q <= reg_list[rn];
            end
            if (accept) begin
                list_q      <= list_next;
                addr_q      <= addr_q + 32'(WORD_BYTES);
                pend_addr_q <= cur_idx;
                pend_data_q <= mem_rdata;
            end
        end
    end

    // NOTE: every output and state_d gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        pc_loaded  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rf_rd_addr = '0;
        rf_w_en    = pend_q;
        rf_w_addr  = pend_q ? pend_addr_q : '0;
        rf_w_data  = pend_q ? pend_data_q : '0;

        case (state_q)
            IDLE: begin
                if (start) state_d = (reg_list != '0) ? XFER : DONE;
            end
            XFER: begin
                busy       = 1'b1;
                mem_req    = any_left;
                mem_we     = ~load_q;
                mem_addr   = addr_q;
                rf_rd_addr = cur_idx;
                mem_wdata  = rf_rd_data;
                if (last_beat) state_d = LAST;
            end
            LAST: begin
                busy    = 1'b1;
                // A loaded Rn must not be overwritten by the writeback value.
                state_d = (wback_q && !(load_q && rn_hit_q)) ? WB : DONE;
            end
            WB: begin
                busy      = 1'b1;
                rf_w_en   = 1'b1;
                rf_w_addr = rn_q;
                rf_w_data = wb_val_q;
                state_d   = DONE;
            end
            DONE: begin
                done      = 1'b1;
                pc_loaded = load_q & pc_bit_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Directed bench for block_xfer_seq: memory data = 0xD000_0000 | addr[15:0],
// register file Ri reads as 0x1100_0000 | i.
module tb_block_xfer_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] reg_list = '0;
    logic [3:0]  rn = '0;
    logic [31:0] base_val = '0;
    logic [1:0]  mode = '0;
    logic        load = 1'b0;
    logic        wback = 1'b0;
    logic        busy, done, pc_loaded, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rf_rd_data, rf_w_data;
    logic        mem_ready = 1'b1;
    logic [3:0]  rf_rd_addr, rf_w_addr;
    logic        rf_w_en;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    logic [31:0] b_addr[$];
    logic        b_we[$];
    logic [31:0] b_wdata[$];
    logic [3:0]  w_addr[$];
    logic [31:0] w_data[$];
    logic        req_seen;

    always #5 clk = ~clk;

    assign mem_rdata  = 32'hD000_0000 | {16'h0, mem_addr[15:0]};
    assign rf_rd_data = 32'h1100_0000 | {28'h0, rf_rd_addr};

    block_xfer_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reg_list   (reg_list),
        .rn         (rn),
        .base_val   (base_val),
        .mode       (mode),
        .load       (load),
        .wback      (wback),
        .busy       (busy),
        .done       (done),
        .pc_loaded  (pc_loaded),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_w_en    (rf_w_en),
        .rf_w_addr  (rf_w_addr),
        .rf_w_data  (rf_w_data)
    );

    // Log accepted beats and register-file writes mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (mem_req) req_seen = 1'b1;
        if (mem_req && mem_ready) begin
            b_addr.push_back(mem_addr);
            b_we.push_back(mem_we);
            b_wdata.push_back(mem_wdata);
        end
        if (rf_w_en) begin
            w_addr.push_back(rf_w_addr);
            w_data.push_back(rf_w_data);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        b_addr.delete();
        b_we.delete();
        b_wdata.delete();
        w_addr.delete();
        w_data.delete();
        req_seen = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] list, input logic [3:0] rn_i, input logic [31:0] base,
                            input logic [1:0] md, input logic ld, input logic w);
        reg_list = list;
        rn       = rn_i;
        base_val = base;
        mode     = md;
        load     = ld;
        wback    = w;
        start    = 1'b1;
        clear_logs();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int l);
        l = from;
        while (!done && l < 60) begin
            tick();
            l++;
        end
    endtask

    task automatic finish_seq(input string tag, input int l, input int exp_l, input logic exp_pc);
        check({tag, "_latency"}, 128'(l), 128'(exp_l));
        check({tag, "_done_busy_pc"}, 128'({done, busy, pc_loaded}), 128'({1'b1, 1'b0, exp_pc}));
        tick();
        check({tag, "_done_one_cycle"}, 128'({done, busy}), 128'(2'b00));
    endtask

    task automatic exp_counts(input string tag, input int nb, input int nw);
        check({tag, "_beat_count"}, 128'(b_addr.size()), 128'(nb));
        check({tag, "_write_count"}, 128'(w_addr.size()), 128'(nw));
    endtask

    task automatic exp_beat(input string tag, input int k, input logic [31:0] a, input logic we,
                            input logic [31:0] wd);
        if (k < b_addr.size()) begin
            check({tag, "_beat_addr"}, 128'(b_addr[k]), 128'(a));
            check({tag, "_beat_we"}, 128'(b_we[k]), 128'(we));
            if (we) check({tag, "_beat_wdata"}, 128'(b_wdata[k]), 128'(wd));
        end
    endtask

    task automatic exp_write(input string tag, input int k, input logic [3:0] a, input logic [31:0] d);
        if (k < w_addr.size()) begin
            check({tag, "_wr_addr"}, 128'(w_addr[k]), 128'(a));
            check({tag, "_wr_data"}, 128'(w_data[k]), 128'(d));
        end
    endtask

    function automatic logic [109:0] all_outputs();
        return {busy, done, pc_loaded, mem_req, mem_we, mem_addr, mem_wdata,
                rf_rd_addr, rf_w_en, rf_w_addr, rf_w_data};
    endfunction

    initial begin
        clear_logs();
        repeat (3) tick();
        check("reset_outputs", 128'(all_outputs()), 128'(0));
        rst = 1'b0;
        tick();
        check("idle_outputs", 128'(all_outputs()), 128'(0));

        // LDM IA R1,R2 from 0x100, W=1, Rn=R5.
        mem_ready = 1'b1;
        do_start(16'h0006, 4'd5, 32'h100, 2'd0, 1'b1, 1'b1);
        check("ia_busy", 128'(busy), 128'(1));
        wait_done(1, lat);
        finish_seq("ia", lat, 5, 1'b0);
        exp_counts("ia", 2, 3);
        exp_beat("ia", 0, 32'h100, 1'b0, 32'h0);
        exp_beat("ia", 1, 32'h104, 1'b0, 32'h0);
        exp_write("ia", 0, 4'd1, 32'hD000_0100);
        exp_write("ia", 1, 4'd2, 32'hD000_0104);
        exp_write("ia", 2, 4'd5, 32'h108);

        // STM DB R0,R15 from 0x200, W=1, Rn=R4; a stray start mid-sequence is ignored.
        do_start(16'h8001, 4'd4, 32'h200, 2'd3, 1'b0, 1'b1);
        reg_list = 16'hFFFF;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(2, lat);
        finish_seq("db", lat, 5, 1'b0);
        exp_counts("db", 2, 1);
        exp_beat("db", 0, 32'h1F8, 1'b1, 32'h1100_0000);
        exp_beat("db", 1, 32'h1FC, 1'b1, 32'h1100_000F);
        exp_write("db", 0, 4'd4, 32'h1F8);

        // LDM IB R3 with Rn=R3, W=1: loaded value wins, no writeback.
        do_start(16'h0008, 4'd3, 32'h40, 2'd1, 1'b1, 1'b1);
        wait_done(1, lat);
        finish_seq("ib", lat, 3, 1'b0);
        exp_counts("ib", 1, 1);
        exp_beat("ib", 0, 32'h44, 1'b0, 32'h0);
        exp_write("ib", 0, 4'd3, 32'hD000_0044);

        // LDM DA R4,R5 from 0x80 with 3 stall cycles per beat, W=1, Rn=R2.
        mem_ready = 1'b0;
        do_start(16'h0030, 4'd2, 32'h80, 2'd2, 1'b1, 1'b1);
        lat = 1;
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 4; s++) begin
                check("da_hold", 128'({mem_req, mem_addr}),
                      128'({1'b1, (b == 0) ? 32'h7C : 32'h80}));
                if (s == 3) mem_ready = 1'b1;
                tick();
                lat++;
                mem_ready = 1'b0;
            end
        end
        wait_done(lat, lat);
        finish_seq("da", lat, 11, 1'b0);
        exp_counts("da", 2, 3);
        exp_write("da", 0, 4'd4, 32'hD000_007C);
        exp_write("da", 1, 4'd5, 32'hD000_0080);
        exp_write("da", 2, 4'd2, 32'h78);
        mem_ready = 1'b1;

        // Empty list: straight to DONE, no beats, no writes.
        do_start(16'h0000, 4'd6, 32'h300, 2'd0, 1'b1, 1'b1);
        finish_seq("empty", 1, 1, 1'b0);
        check("empty_no_req", 128'(req_seen), 128'(0));
        exp_counts("empty", 0, 0);

        // LDM IA R15 only: pc_loaded at done.
        do_start(16'h8000, 4'd0, 32'h10, 2'd0, 1'b1, 1'b0);
        wait_done(1, lat);
        finish_seq("pc", lat, 3, 1'b1);
        exp_counts("pc", 1, 1);
        exp_write("pc", 0, 4'd15, 32'hD000_0010);

        // Reset during the second beat of a 4-register LDM.
        do_start(16'h00F0, 4'd1, 32'h300, 2'd0, 1'b1, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_outputs", 128'(all_outputs()), 128'(0));
        clear_logs();
        tick();
        check("rst_mid_idle", 128'(all_outputs()), 128'(0));
        exp_counts("rst_mid_idle", 0, 0);

        do_start(16'h0002, 4'd0, 32'h500, 2'd0, 1'b1, 1'b0);
        wait_done(1, lat);
        finish_seq("post_rst", lat, 3, 1'b0);
        exp_counts("post_rst", 1, 1);
        exp_beat("post_rst", 0, 32'h500, 1'b0, 32'h0);
        exp_write("post_rst", 0, 4'd1, 32'hD000_0500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
